alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//   Parametrised successor to the single-cycle 8-bit datapath ALU.
//   Adds registered results, a START/BUSY/DONE handshake, and two iterative ops:
//     - a multi-bit shift-left
//     - an unsigned shift-add multiply with a 2*WIDTH product
//   Sits between the register file and the writeback mux. The control FSM stalls
//   the fetch/issue stage while BUSY is high.
// PARAMETERS
//   WIDTH  8                 operand/result width in bits; must be >= 2
//   SHW    $clog2(WIDTH)     shift-amount width; derived, do not override
// PORTS
//   CLK      in   1      rising-edge clock
//   RESET_N  in   1      asynchronous reset, active low
//   START    in   1      request; sampled only when BUSY=0
//   OP       in   3      000 ADD, 001 SUB, 010 XOR, 011 AND, 100 CMP, 101 MOV, 110 SHL, 111 MUL
//   INPUTA   in   WIDTH  operand A
//   INPUTB   in   WIDTH  operand B; SHL uses INPUTB[SHW-1:0] as the shift amount
//   SC_IN    in   1      carry in (ADD) / shift-in bit (SHL)
//   BUSY     out  1      iterative op in progress
//   DONE     out  1      one-cycle pulse; results valid from this cycle on
//   OUT      out  WIDTH  result (MUL: low half)
//   OUT_HI   out  WIDTH  MUL high half; 0 for every other op
//   SC_OUT   out  1      carry/no-borrow/last bit shifted out
//   ZERO     out  1      1 when the full result is zero ({OUT_HI,OUT})
// BEHAVIOUR
//   Reset (RESET_N=0, any time, including mid-op):
//     - state=IDLE; BUSY, DONE, OUT, OUT_HI, SC_OUT, ZERO all 0
//     - iteration counter and accumulators cleared; in-flight op discarded, no DONE
//   FSM: IDLE, SHIFT, MUL.
//   Capture:
//     - START=1 with BUSY=0 at an edge latches OP, INPUTA, INPUTB and SC_IN.
//     - Operands are held internally; input changes after capture are ignored.
//   Single-cycle ops (ADD, SUB, XOR, AND, CMP, MOV, and SHL with shamt 0):
//     - Result is written at the capture edge.
//     - DONE=1 the following cycle; BUSY stays 0. Latency = 1.
//   SHL, shamt n >= 1:
//     - Capture edge -> SHIFT with BUSY=1.
//     - Each following edge does {c,acc} <= {acc,SC_IN_latched}.
//     - The n-th iteration edge writes OUT=acc and SC_OUT=last bit shifted out,
//       goes to IDLE, and sets DONE. Latency = n+1.
//   MUL (unsigned):
//     - Capture edge -> MUL.
//     - WIDTH shift-add iterations of one bit of B per edge, LSB first.
//     - The final edge writes {OUT_HI,OUT}=A*B, SC_OUT=0, DONE. Latency = WIDTH+1.
//   Per-op results:
//     - ADD: {SC_OUT,OUT} = A + B + SC_IN
//     - SUB: {SC_OUT,OUT} = A + ~B + 1; SC_OUT=1 means no borrow
//     - XOR, AND: SC_OUT = 0
//     - CMP: OUT=0, ZERO=1 if A==B; else OUT=1, ZERO=0; SC_OUT=0
//     - MOV: OUT = B; SC_OUT = 0
//   Arithmetic is modulo 2^WIDTH; the carry goes to SC_OUT only.
//   Output registers update only on completion edges; otherwise they hold.
//   ZERO is registered alongside OUT.
//   BUSY and DONE timing:
//     - BUSY is 1 from the capture edge up to the completion edge.
//     - BUSY is 0 in the DONE cycle, so START can be accepted back-to-back then.
//     - START while BUSY=1 is ignored: not queued, no effect on the current op.
//   DONE is exactly one cycle wide, even with back-to-back starts.
// TESTING
//   1. ADD A=8'hFF, B=8'h01, SC_IN=0 -> next cycle DONE=1, OUT=8'h00, SC_OUT=1, ZERO=1, BUSY never high.
//   2. SHL A=8'hB3, B=8'h01, SC_IN=1 -> DONE at cycle 2, OUT=8'h67, SC_OUT=1.
//      Then B=8'h03, SC_IN=0 -> DONE at cycle 4, OUT=8'h98, SC_OUT=1.
//   3. MUL A=8'd15, B=8'd17 -> BUSY high 8 cycles, DONE at cycle 9, {OUT_HI,OUT}=16'h00FF, ZERO=0.
//      MUL 8'hFF*8'hFF -> 16'hFE01.
//   4. Start MUL 3*5; pulse START with ADD 1+1 at cycle 4 -> ADD ignored; DONE once at cycle 9, OUT=8'd15.
//   5. Assert RESET_N=0 at cycle 5 of a MUL -> all outputs 0 immediately, no DONE.
//      After release, SUB A=8'h05, B=8'h07 -> OUT=8'hFE, SC_OUT=0.
//   6. CMP 8'h5A vs 8'h5A -> OUT=0, ZERO=1. Back-to-back CMP 8'h5A vs 8'h5B in the DONE cycle -> OUT=1, ZERO=0.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with a START/BUSY/DONE handshake.
// Single-cycle ops complete at the capture edge. SHL by n >= 1 and the
// unsigned shift-add MUL iterate in dedicated states. Results are registered
// and held until the next completion edge.
module alu_multicycle #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] INPUTA,
  input  logic [WIDTH-1:0] INPUTB,
  input  logic             SC_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             SC_OUT,
  output logic             ZERO
);

  // Counter must hold WIDTH itself (MUL iteration count), not just WIDTH-1.
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_XOR = 3'b010,
    OP_AND = 3'b011,
    OP_CMP = 3'b100,
    OP_MOV = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             sc_q, sc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_hi_q, out_hi_d;
  logic             sc_out_q, sc_out_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  op_t              op_in;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic [WIDTH-1:0] shl_next;
  logic             shl_carry;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign op_in = op_t'(OP);
  assign shamt = INPUTB[SHW-1:0];

  // Single-cycle result straight from the input operands, used at the capture edge.
  always_comb begin
    sum      = '0;
    sc_res   = '0;
    sc_carry = 1'b0;
    case (op_in)
      OP_ADD: begin
        sum      = {1'b0, INPUTA} + {1'b0, INPUTB} + (WIDTH + 1)'(SC_IN);
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
      end
      OP_SUB: begin
        sum      = {1'b0, INPUTA} + {1'b0, ~INPUTB} + (WIDTH + 1)'(1'b1);
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
      end
      OP_XOR: sc_res = INPUTA ^ INPUTB;
      OP_AND: sc_res = INPUTA & INPUTB;
      OP_CMP: sc_res = (INPUTA == INPUTB) ? '0 : WIDTH'(1);
      OP_MOV: sc_res = INPUTB;
      OP_SHL: sc_res = INPUTA;
      default: sc_res = '0;
    endcase
  end

  // One iteration of each iterative op, computed from the held operands.
  always_comb begin
    shl_next  = {acc_lo_q[WIDTH-2:0], sc_q};
    shl_carry = acc_lo_q[WIDTH-1];
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? a_q : '0)};
    mul_next  = {mul_sum, acc_lo_q[WIDTH-1:1]};
  end

  // Next-state and next-register logic; outputs change only on completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    sc_d     = sc_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    sc_out_d = sc_out_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (op_in == OP_SHL && shamt != '0) begin
            acc_lo_d = INPUTA;
            sc_d     = SC_IN;
            cnt_d    = CW'(shamt);
            state_d  = SHIFT;
          end else if (op_in == OP_MUL) begin
            a_d      = INPUTA;
            acc_hi_d = '0;
            acc_lo_d = INPUTB;
            cnt_d    = CW'(WIDTH);
            state_d  = MUL;
          end else begin
            out_d    = sc_res;
            out_hi_d = '0;
            sc_out_d = sc_carry;
            zero_d   = (sc_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_lo_d = shl_next;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d    = shl_next;
          out_hi_d = '0;
          sc_out_d = shl_carry;
          zero_d   = (shl_next == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      MUL: begin
        acc_hi_d = mul_next[2*WIDTH-1:WIDTH];
        acc_lo_d = mul_next[WIDTH-1:0];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d    = mul_next[WIDTH-1:0];
          out_hi_d = mul_next[2*WIDTH-1:WIDTH];
          sc_out_d = 1'b0;
          zero_d   = (mul_next == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      sc_q     <= 1'b0;
      out_q    <= '0;
      out_hi_q <= '0;
      sc_out_q <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      sc_q     <= sc_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      sc_out_q <= sc_out_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = (state_q != IDLE);
  assign DONE   = done_q;
  assign OUT    = out_q;
  assign OUT_HI = out_hi_q;
  assign SC_OUT = sc_out_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes expected results,
// a negedge monitor pops and compares whenever DONE is seen.
module tb_alu_multicycle;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       START;
  logic [2:0] OP;
  logic [7:0] INPUTA, INPUTB;
  logic       SC_IN;
  logic       BUSY, DONE, SC_OUT, ZERO;
  logic [7:0] OUT, OUT_HI;

  alu_multicycle #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP),
    .INPUTA(INPUTA), .INPUTB(INPUTB), .SC_IN(SC_IN),
    .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .OUT_HI(OUT_HI),
    .SC_OUT(SC_OUT), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  out;
    logic [7:0]  hi;
    logic        sc;
    logic        zero;
    int unsigned cyc;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total  = 0;
  int   passes = 0;

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, tag, act, exp);
    else
      passes++;
  endtask

  always @(negedge CLK) begin
    if (DONE) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: cycle %0d got DONE=1 expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("out",        mon_e.tag, 32'(OUT),    32'(mon_e.out));
        chk("out_hi",     mon_e.tag, 32'(OUT_HI), 32'(mon_e.hi));
        chk("sc_out",     mon_e.tag, 32'(SC_OUT), 32'(mon_e.sc));
        chk("zero",       mon_e.tag, 32'(ZERO),   32'(mon_e.zero));
        chk("done_cycle", mon_e.tag, cyc,         mon_e.cyc);
        chk("busy_done",  mon_e.tag, 32'(BUSY),   32'd0);
      end
    end
  end

  // Called at a negedge; returns at the next negedge with START dropped and
  // the operand inputs scrambled so that capture-only sampling is exercised.
  task automatic start_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic sc, input logic [7:0] eo, input logic [7:0] ehi,
                          input logic esc, input logic ez, input int unsigned iters,
                          input int tag);
    exp_t e;
    e.out = eo; e.hi = ehi; e.sc = esc; e.zero = ez;
    e.cyc = cyc + 1 + iters; e.tag = tag;
    sb.push_back(e);
    OP = op; INPUTA = a; INPUTB = b; SC_IN = sc; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; INPUTA = ~a; INPUTB = ~b; SC_IN = ~sc;
  endtask

  task automatic wait_drain(input int tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout (vec %0d): got %0d pending expected 0", tag, sb.size());
      sb.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    RESET_N = 1'b0; START = 1'b0; OP = '0; INPUTA = '0; INPUTB = '0; SC_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy",   0, 32'(BUSY),   32'd0);
    chk("rst_done",   0, 32'(DONE),   32'd0);
    chk("rst_out",    0, 32'(OUT),    32'd0);
    chk("rst_out_hi", 0, 32'(OUT_HI), 32'd0);
    chk("rst_sc_out", 0, 32'(SC_OUT), 32'd0);
    chk("rst_zero",   0, 32'(ZERO),   32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Single-cycle ops
    start_op(3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 0, 1);
    wait_drain(1);
    start_op(3'b000, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 0, 2);
    wait_drain(2);
    start_op(3'b001, 8'h07, 8'h05, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 0, 3);
    wait_drain(3);
    start_op(3'b010, 8'hA5, 8'h5A, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 0, 4);
    wait_drain(4);
    start_op(3'b011, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 0, 5);
    wait_drain(5);
    start_op(3'b101, 8'h12, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 0, 6);
    wait_drain(6);
    start_op(3'b110, 8'h5A, 8'h00, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 0, 7);
    wait_drain(7);

    // Iterative shifts
    start_op(3'b110, 8'hB3, 8'h01, 1'b1, 8'h67, 8'h00, 1'b1, 1'b0, 1, 8);
    wait_drain(8);
    start_op(3'b110, 8'hB3, 8'h03, 1'b0, 8'h98, 8'h00, 1'b1, 1'b0, 3, 9);
    wait_drain(9);
    start_op(3'b110, 8'h01, 8'h07, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 7, 10);
    wait_drain(10);
    start_op(3'b110, 8'hFF, 8'h07, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 7, 11);
    wait_drain(11);

    // MUL: BUSY high for exactly WIDTH cycles before DONE
    start_op(3'b111, 8'd15, 8'd17, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8, 12);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", 12, 32'(BUSY), 32'd1);
      @(negedge CLK);
    end
    wait_drain(12);
    start_op(3'b111, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b0, 8, 13);
    wait_drain(13);

    // START during MUL is ignored
    start_op(3'b111, 8'd3, 8'd5, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b0, 8, 14);
    repeat (2) @(negedge CLK);
    OP = 3'b000; INPUTA = 8'd1; INPUTB = 8'd1; SC_IN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_drain(14);
    repeat (3) @(negedge CLK);

    // Reset in the middle of a MUL discards it
    start_op(3'b111, 8'hC3, 8'h11, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8, 15);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_busy",   15, 32'(BUSY),   32'd0);
    chk("mid_rst_done",   15, 32'(DONE),   32'd0);
    chk("mid_rst_out",    15, 32'(OUT),    32'd0);
    chk("mid_rst_out_hi", 15, 32'(OUT_HI), 32'd0);
    chk("mid_rst_sc_out", 15, 32'(SC_OUT), 32'd0);
    chk("mid_rst_zero",   15, 32'(ZERO),   32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (12) @(negedge CLK);
    start_op(3'b001, 8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b0, 0, 16);
    wait_drain(16);

    // CMP, then back-to-back CMP in the DONE cycle
    start_op(3'b100, 8'h5A, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 0, 17);
    start_op(3'b100, 8'h5A, 8'h5B, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 0, 18);
    wait_drain(18);
    repeat (3) @(negedge CLK);

    chk("sb_empty", 99, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
